cyclotron_ibuffer_bank: RTL
===========================

# cyclotron_ibuffer_bank

Per-warp instruction buffer bank between the Cyclotron frontend (fetch/decode) and the issue stage. One shared enqueue port writes decoded instructions tagged with a warp id into one of NUM_WARPS independent FIFOs of configurable DEPTH. Each warp has its own ready/valid dequeue head. Per-warp flush supports branch/divergence redirect, and per-warp occupancy and almost-full outputs let fetch throttle.

## Interface

Parameters:
- NUM_WARPS, 8, number of warps / FIFOs
- NUM_LANES, 16, thread-mask width
- ARCH_LEN, 32, PC width
- PAYLOAD_BITS, 128, packed decoded fields (op, rd, rs1–3, imm32, imm24, csrImm, f3, f7, pred, raw); opaque to this block
- DEPTH, 4, entries per warp; power of 2, ≥2
- AF_MARGIN, 1, almost-full asserts when count ≥ DEPTH−AF_MARGIN; range 0..DEPTH−1

Ports (WID = clog2(NUM_WARPS), CNT = clog2(DEPTH+1)):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- enq_ready  out  1  space in FIFO enq_bits_wid
- enq_valid  in  1  enqueue request
- enq_bits_wid  in  WID  target warp
- enq_bits_pc  in  ARCH_LEN  instruction PC
- enq_bits_tmask  in  NUM_LANES  thread mask
- enq_bits_payload  in  PAYLOAD_BITS  decoded instruction
- flush  in  NUM_WARPS  per-warp flush request
- deq_ready  in  NUM_WARPS  per-warp issue ready
- deq_valid  out  NUM_WARPS  per-warp head valid
- deq_bits_pc  out  NUM_WARPS*ARCH_LEN  head PC; warp w at [ARCH_LEN*w +: ARCH_LEN]
- deq_bits_tmask  out  NUM_WARPS*NUM_LANES  head thread mask
- deq_bits_payload  out  NUM_WARPS*PAYLOAD_BITS  head payload
- count  out  NUM_WARPS*CNT  per-warp occupancy
- almost_full  out  NUM_WARPS  per-warp fetch-throttle hint

## Operation

- Per warp w: storage of DEPTH entries {pc, tmask, payload}, head pointer, tail pointer (log2 DEPTH bits each, wrap modulo DEPTH), and count (0..DEPTH).
- enq_ready = !reset && count[enq_bits_wid] < DEPTH. This is a combinational path from enq_bits_wid. No pass-through of a slot freed by a same-cycle dequeue.
- Enqueue fires when enq_valid && enq_ready. The entry is written at tail[wid], then tail and count advance.
- Dequeue fires for warp w when deq_valid[w] && deq_ready[w]. Head and count advance.
- deq_valid[w] = count[w] != 0. No empty bypass.
- deq_bits_* for warp w are forced to 0 whenever deq_valid[w] = 0. Storage itself is not reset.
- Same-cycle enqueue and dequeue on warp w: count unchanged, both pointers advance. Legal at full: the enqueue is refused because enq_ready was 0.
- Flush of warp w:
  - Next cycle: head = tail = 0 and count = 0.
  - An enqueue to w in the flush cycle is discarded (flush wins). enq_ready is not gated by flush.
  - A dequeue handshake on w in the flush cycle completes normally, since the head was valid.
  - Other warps are unaffected.
- almost_full[w] = count[w] ≥ DEPTH−AF_MARGIN.
- Out-of-range enq_bits_wid (≥ NUM_WARPS, non-power-of-2 configs): enq_ready = 0 and no state change.
- Reset asserted mid-operation: all FIFOs empty immediately (asynchronous), and enq_ready = 0 for as long as reset is high.

## Timing

Reset values:
- enq_ready 0
- deq_valid all 0
- deq_bits_* all 0
- count all 0
- almost_full all 0 when AF_MARGIN < DEPTH (count 0 is below threshold)

Latency and throughput:
- Enqueue-to-deq_valid latency is 1 cycle: deq_valid rises on the edge after the enqueue fire.
- Enqueue throughput: 1 instruction per cycle total, across all warps.
- Dequeue throughput: 1 instruction per cycle per warp, for all warps in parallel.

Timing paths:
- count and almost_full are registered-state functions and update the cycle after a fire or flush.
- enq_ready is combinational from registered count plus enq_bits_wid.

## Structure

- Package cyclotron_ibuf_pkg holds:
  - derived widths WID and CNT and the pointer width
  - packed struct ibuf_entry_t {pc, tmask, payload}
  - helper function for warp-slice indexing
- Sub-module cyclotron_ibuf_warp_fifo:
  - single-warp DEPTH-entry FIFO with flush, count and almost-full
  - generated NUM_WARPS times
  - top level does wid decode, enq_ready mux and output flattening

## Test plan

- Reset, then enqueue pc=0x100 to wid=3 → next cycle deq_valid=0x08, deq_bits_pc[3]=0x100, count[3]=1; every other warp deq_valid=0 with zero outputs.
- DEPTH=4, AF_MARGIN=1: fill wid=0 with pcs 0x0,0x4,0x8,0xC, no deq_ready → almost_full[0] rises after the 3rd enqueue. After the 4th, enq_ready=0 for wid=0 and 1 for wid=1. Drain → pcs emerge in order, and pointers wrap correctly on a refill of 6 entries.
- Warp 2 full, enq_valid to wid 2 with deq_ready[2]=1 in the same cycle → dequeue fires, enqueue refused; count[2]=3 next cycle.
- Warp 5 holding 2 entries: in one cycle assert flush[5], enq to wid 5, and deq_ready[5] → the head handshake completes, the new entry is discarded, count[5]=0 next cycle, and warps 0–4/6–7 keep their counts.
- All 8 warps with 1 entry each, deq_ready=0xFF for one cycle → all deq_valid drop next cycle; count all 0.
- Assert reset asynchronously mid-stream with 3 warps occupied → deq_valid=0, count=0 and enq_ready=0 before the next clock edge. After deassertion, enq_ready=1.

Source files
------------

// File: rtl/cyclotron_ibuf_pkg.sv
// Shared widths, entry layout and indexing helpers for the Cyclotron
// per-warp instruction buffer bank.
package cyclotron_ibuf_pkg;

    localparam int IBUF_NUM_WARPS    = 8;
    localparam int IBUF_NUM_LANES    = 16;
    localparam int IBUF_ARCH_LEN     = 32;
    localparam int IBUF_PAYLOAD_BITS = 128;
    localparam int IBUF_DEPTH        = 4;

    function automatic int ibuf_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ibuf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ibuf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Low bit of warp w's field in a flattened per-warp output bus.
    function automatic int ibuf_slice_lo(input int w, input int width);
        return w * width;
    endfunction

    localparam int IBUF_WID   = ibuf_idx_w(IBUF_NUM_WARPS);
    localparam int IBUF_CNT   = ibuf_cnt_w(IBUF_DEPTH);
    localparam int IBUF_PTR_W = ibuf_ptr_w(IBUF_DEPTH);

    // Entry layout for the default configuration; pc sits in the MSBs.
    typedef struct packed {
        logic [IBUF_ARCH_LEN-1:0]     pc;
        logic [IBUF_NUM_LANES-1:0]    tmask;
        logic [IBUF_PAYLOAD_BITS-1:0] payload;
    } ibuf_entry_t;

endpackage

// File: rtl/cyclotron_ibuf_warp_fifo.sv
// Single-warp instruction FIFO: DEPTH entries, flush to empty, occupancy
// and almost-full. Storage is not reset; only pointers and count are.
module cyclotron_ibuf_warp_fifo
    import cyclotron_ibuf_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int AF_MARGIN = 1,
    parameter  int ENTRY_W   = 176,
    localparam int CNT       = ibuf_cnt_w(DEPTH),
    localparam int PTR_W     = ibuf_ptr_w(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enq_fire,
    input  logic [ENTRY_W-1:0] enq_data,
    input  logic               flush,
    input  logic               deq_ready,
    output logic               deq_valid,
    output logic [ENTRY_W-1:0] deq_data,
    output logic [CNT-1:0]     count,
    output logic               almost_full
);

    localparam logic [CNT-1:0] AF_TH = CNT'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               enq_ok, deq_fire;

    assign deq_valid   = (count_q != '0);
    assign deq_fire    = deq_valid && deq_ready;
    // Flush wins over a same-cycle enqueue; the dequeue still completes.
    assign enq_ok      = enq_fire && !flush;
    assign deq_data    = deq_valid ? mem_q[head_q] : '0;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_TH);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq_fire) head_d = head_q + PTR_W'(1);
            if (enq_ok)   tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CNT'(enq_ok) - CNT'(deq_fire);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_ok) mem_q[tail_q] <= enq_data;
    end

endmodule

// File: rtl/cyclotron_ibuffer_bank.sv
// Per-warp instruction buffer bank: one shared enqueue port steered by warp id
// into NUM_WARPS independent FIFOs, each with its own ready/valid head.
module cyclotron_ibuffer_bank
    import cyclotron_ibuf_pkg::*;
#(
    parameter  int NUM_WARPS    = 8,
    parameter  int NUM_LANES    = 16,
    parameter  int ARCH_LEN     = 32,
    parameter  int PAYLOAD_BITS = 128,
    parameter  int DEPTH        = 4,
    parameter  int AF_MARGIN    = 1,
    localparam int WID          = ibuf_idx_w(NUM_WARPS),
    localparam int CNT          = ibuf_cnt_w(DEPTH)
) (
    input  logic                              clock,
    input  logic                              reset,
    output logic                              enq_ready,
    input  logic                              enq_valid,
    input  logic [WID-1:0]                    enq_bits_wid,
    input  logic [ARCH_LEN-1:0]               enq_bits_pc,
    input  logic [NUM_LANES-1:0]              enq_bits_tmask,
    input  logic [PAYLOAD_BITS-1:0]           enq_bits_payload,
    input  logic [NUM_WARPS-1:0]              flush,
    input  logic [NUM_WARPS-1:0]              deq_ready,
    output logic [NUM_WARPS-1:0]              deq_valid,
    output logic [NUM_WARPS*ARCH_LEN-1:0]     deq_bits_pc,
    output logic [NUM_WARPS*NUM_LANES-1:0]    deq_bits_tmask,
    output logic [NUM_WARPS*PAYLOAD_BITS-1:0] deq_bits_payload,
    output logic [NUM_WARPS*CNT-1:0]          count,
    output logic [NUM_WARPS-1:0]              almost_full
);

    localparam int ENTRY_W = ARCH_LEN + NUM_LANES + PAYLOAD_BITS;

    logic [ENTRY_W-1:0]                  enq_data;
    logic [NUM_WARPS-1:0]                enq_fire, full;
    logic [NUM_WARPS-1:0][ENTRY_W-1:0]   deq_data;
    logic [NUM_WARPS-1:0][CNT-1:0]       cnt;
    logic                                sel_full;

    assign enq_data = {enq_bits_pc, enq_bits_tmask, enq_bits_payload};

    // Ids with no matching warp read as full, so they never fire.
    always_comb begin
        sel_full = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (enq_bits_wid == WID'(w)) sel_full = full[w];
        end
    end

    assign enq_ready = !reset && !sel_full;
    assign count     = cnt;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign full[w]     = (cnt[w] == CNT'(DEPTH));
        assign enq_fire[w] = enq_valid && enq_ready && (enq_bits_wid == WID'(w));

        cyclotron_ibuf_warp_fifo #(
            .DEPTH     (DEPTH),
            .AF_MARGIN (AF_MARGIN),
            .ENTRY_W   (ENTRY_W)
        ) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .enq_fire    (enq_fire[w]),
            .enq_data    (enq_data),
            .flush       (flush[w]),
            .deq_ready   (deq_ready[w]),
            .deq_valid   (deq_valid[w]),
            .deq_data    (deq_data[w]),
            .count       (cnt[w]),
            .almost_full (almost_full[w])
        );

        assign deq_bits_pc[ibuf_slice_lo(w, ARCH_LEN) +: ARCH_LEN] =
            deq_data[w][ENTRY_W-1 -: ARCH_LEN];
        assign deq_bits_tmask[ibuf_slice_lo(w, NUM_LANES) +: NUM_LANES] =
            deq_data[w][PAYLOAD_BITS +: NUM_LANES];
        assign deq_bits_payload[ibuf_slice_lo(w, PAYLOAD_BITS) +: PAYLOAD_BITS] =
            deq_data[w][PAYLOAD_BITS-1:0];
    end

endmodule
